// File: rtl/audio_arbiter_if.sv
// rtl/audio_arbiter_if.sv - music/effect request and tone-generator bus for the audio arbiter
interface audio_arbiter_if;
  logic [23:0] i_music_freq;
  logic [2:0]  i_sfx_req;
  logic        i_mute;
  logic [23:0] o_freq;
  logic        o_sfx_active;
  logic [1:0]  o_sfx_id;
  logic        o_done;

  // Arbiter side: consumes requests, drives the tone generator frequency
  modport slave (
    input  i_music_freq,
    input  i_sfx_req,
    input  i_mute,
    output o_freq,
    output o_sfx_active,
    output o_sfx_id,
    output o_done
  );

  // Game-logic side: issues requests, observes the arbiter
  modport master (
    output i_music_freq,
    output i_sfx_req,
    output i_mute,
    input  o_freq,
    input  o_sfx_active,
    input  o_sfx_id,
    input  o_done
  );
endinterface

// File: rtl/audio_arbiter.sv
// rtl/audio_arbiter.sv - shares one tone generator between background music and prioritised effects
module audio_arbiter #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 64
) (
  input  logic            i_clk,
  input  logic            i_rst,
  audio_arbiter_if.slave  bus
);

  localparam int STEP_CYC = CLK_HZ / STEP_HZ;
  localparam int CW       = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_PLAY = 1'b1;

  // Effect ids double as priority: a larger id always wins
  localparam logic [1:0] ID_LASER = 2'd0;
  localparam logic [1:0] ID_EXPL  = 2'd1;
  localparam logic [1:0] ID_HIT   = 2'd2;
  localparam logic [1:0] ID_NONE  = 2'd3;

  logic [0:0]    r_state;
  logic [1:0]    r_id;
  logic [3:0]    r_step;
  logic [CW-1:0] r_cyc;
  logic [2:0]    r_pend;
  logic [23:0]   r_freq;
  logic          r_done;

  logic [0:0]    w_state_n;
  logic [1:0]    w_id_n;
  logic [3:0]    w_step_n;
  logic [CW-1:0] w_cyc_n;
  logic [2:0]    w_pend_n;
  logic [23:0]   w_freq_n;
  logic          w_done_n;
  logic [2:0]    w_cand;
  logic [2:0]    w_higher;
  logic          w_tick;
  logic          w_last;

  function automatic logic [23:0] f_tone(input logic [1:0] id, input logic [3:0] s);
    case (id)
      ID_LASER: f_tone = 24'd1600 - 24'd100 * {20'd0, s};
      ID_EXPL:  f_tone = 24'd200 - 24'd8 * {20'd0, s};
      ID_HIT:   f_tone = s[0] ? 24'd0 : 24'd440;
      default:  f_tone = 24'd0;
    endcase
  endfunction

  function automatic logic [3:0] f_last(input logic [1:0] id);
    case (id)
      ID_LASER: f_last = 4'd7;
      ID_EXPL:  f_last = 4'd15;
      ID_HIT:   f_last = 4'd11;
      default:  f_last = 4'd0;
    endcase
  endfunction

  function automatic logic [1:0] f_hi(input logic [2:0] mask);
    if (mask[2])      f_hi = ID_HIT;
    else if (mask[1]) f_hi = ID_EXPL;
    else              f_hi = ID_LASER;
  endfunction

  function automatic logic [2:0] f_bit(input logic [1:0] id);
    f_bit = 3'b001 << id;
  endfunction

  function automatic logic [2:0] f_above(input logic [1:0] id);
    case (id)
      ID_LASER: f_above = 3'b110;
      ID_EXPL:  f_above = 3'b100;
      default:  f_above = 3'b000;
    endcase
  endfunction

  assign w_tick   = (r_cyc == CW'(STEP_CYC - 1));
  assign w_last   = (r_step == f_last(r_id));
  assign w_higher = bus.i_sfx_req & f_above(r_id);

  // Next-state arbitration: start, preempt, restart, step advance and pending handoff
  always_comb begin
    w_state_n = r_state;
    w_id_n    = r_id;
    w_step_n  = r_step;
    w_cyc_n   = r_cyc;
    w_pend_n  = r_pend;
    w_done_n  = 1'b0;
    w_cand    = 3'b000;
    if (r_state == S_IDLE) begin
      w_cand = bus.i_sfx_req | r_pend;
      if (|w_cand) begin
        w_state_n = S_PLAY;
        w_id_n    = f_hi(w_cand);
        w_step_n  = 4'd0;
        w_cyc_n   = '0;
        w_pend_n  = w_cand & ~f_bit(f_hi(w_cand));
      end
    end else if (|w_higher) begin
      // Aborted effect is dropped entirely, even if re-requested in this cycle
      w_id_n    = f_hi(bus.i_sfx_req);
      w_step_n  = 4'd0;
      w_cyc_n   = '0;
      w_done_n  = 1'b1;
      w_pend_n  = (r_pend | bus.i_sfx_req) & ~f_bit(f_hi(bus.i_sfx_req)) & ~f_bit(r_id);
    end else if (bus.i_sfx_req[r_id]) begin
      w_step_n  = 4'd0;
      w_cyc_n   = '0;
      w_pend_n  = r_pend | (bus.i_sfx_req & ~f_bit(r_id));
    end else begin
      w_pend_n = r_pend | bus.i_sfx_req;
      if (!w_tick) begin
        w_cyc_n = r_cyc + CW'(1);
      end else if (!w_last) begin
        w_cyc_n  = '0;
        w_step_n = r_step + 4'd1;
      end else begin
        w_done_n = 1'b1;
        w_cyc_n  = '0;
        w_step_n = 4'd0;
        w_cand   = w_pend_n;
        if (|w_cand) begin
          w_id_n   = f_hi(w_cand);
          w_pend_n = w_cand & ~f_bit(f_hi(w_cand));
        end else begin
          w_state_n = S_IDLE;
        end
      end
    end
    if (bus.i_mute)
      w_freq_n = 24'd0;
    else if (w_state_n == S_PLAY)
      w_freq_n = f_tone(w_id_n, w_step_n);
    else
      w_freq_n = bus.i_music_freq;
  end

  // State and output registers; reset wins over every request
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_id    <= ID_LASER;
      r_step  <= 4'd0;
      r_cyc   <= '0;
      r_pend  <= 3'b000;
      r_freq  <= 24'd0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_id    <= w_id_n;
      r_step  <= w_step_n;
      r_cyc   <= w_cyc_n;
      r_pend  <= w_pend_n;
      r_freq  <= w_freq_n;
      r_done  <= w_done_n;
    end
  end

  assign bus.o_freq       = r_freq;
  assign bus.o_done       = r_done;
  assign bus.o_sfx_active = (r_state == S_PLAY);
  assign bus.o_sfx_id     = (r_state == S_PLAY) ? r_id : ID_NONE;

endmodule

// File: tb/tb_audio_arbiter.sv
// tb/tb_audio_arbiter.sv - directed self-checking bench for audio_arbiter
module tb_audio_arbiter;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  audio_arbiter_if bus ();

  audio_arbiter #(.CLK_HZ(64), .STEP_HZ(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_sfx_req = 3'b000;
    bus.i_mute = 1'b0;
    bus.i_music_freq = 24'd261;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic start_fx(input logic [2:0] req);
    bus.i_sfx_req = req;
    tick();
    bus.i_sfx_req = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_music_freq = 24'd261;
    bus.i_mute = 1'b0;
    bus.i_sfx_req = 3'b100;
    tick();
    n_tests++;
    if (bus.o_freq !== 24'd0) begin n_fail++; $display("FAIL reset_freq got %0d want 0", bus.o_freq); end
    n_tests++;
    if (bus.o_sfx_active !== 1'b0) begin n_fail++; $display("FAIL reset_active got %0b want 0", bus.o_sfx_active); end
    n_tests++;
    if (bus.o_sfx_id !== 2'd3) begin n_fail++; $display("FAIL reset_id got %0d want 3", bus.o_sfx_id); end
    n_tests++;
    if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.o_done); end
    rst = 1'b0;
    bus.i_sfx_req = 3'b000;
    tick();
    n_tests++;
    if (bus.o_sfx_id !== 2'd3) begin n_fail++; $display("FAIL reset_req_dropped id got %0d want 3", bus.o_sfx_id); end
  endtask

  task automatic test_idle();
    do_reset();
    bus.i_music_freq = 24'd261;
    tick();
    n_tests++;
    if (bus.o_freq !== 24'd261) begin n_fail++; $display("FAIL idle_261 got %0d want 261", bus.o_freq); end
    n_tests++;
    if (bus.o_sfx_id !== 2'd3) begin n_fail++; $display("FAIL idle_id got %0d want 3", bus.o_sfx_id); end
    bus.i_music_freq = 24'd330;
    tick();
    n_tests++;
    if (bus.o_freq !== 24'd330) begin n_fail++; $display("FAIL idle_330 got %0d want 330", bus.o_freq); end
    bus.i_music_freq = 24'd261;
    tick();
  endtask

  task automatic test_laser();
    logic [23:0] ef;
    do_reset();
    start_fx(3'b001);
    for (int k = 1; k <= 66; k++) begin
      ef = (k <= 64) ? 24'(1600 - 100 * ((k - 1) / 8)) : 24'd261;
      if (k != 65) begin
        n_tests++;
        if (bus.o_freq !== ef) begin n_fail++; $display("FAIL laser_freq k=%0d got %0d want %0d", k, bus.o_freq, ef); end
      end
      n_tests++;
      if (bus.o_done !== (k == 65)) begin n_fail++; $display("FAIL laser_done k=%0d got %0b want %0b", k, bus.o_done, k == 65); end
      n_tests++;
      if (bus.o_sfx_id !== ((k <= 64) ? 2'd0 : 2'd3)) begin n_fail++; $display("FAIL laser_id k=%0d got %0d", k, bus.o_sfx_id); end
      tick();
    end
  endtask

  task automatic test_preempt();
    logic [23:0] ef;
    logic [1:0]  ei;
    logic        ed;
    int          h;
    do_reset();
    start_fx(3'b001);
    for (int j = 0; j <= 130; j++) begin
      h = j - 27;
      if (j < 27) begin
        ef = 24'(1600 - 100 * (j / 8)); ei = 2'd0; ed = 1'b0;
      end else if (h < 96) begin
        ef = ((h / 8) % 2 == 0) ? 24'd440 : 24'd0; ei = 2'd2; ed = (h == 0);
      end else begin
        ef = 24'd261; ei = 2'd3; ed = (h == 96);
      end
      if (h != 96) begin
        n_tests++;
        if (bus.o_freq !== ef) begin n_fail++; $display("FAIL preempt_freq j=%0d got %0d want %0d", j, bus.o_freq, ef); end
      end
      n_tests++;
      if (bus.o_sfx_id !== ei) begin n_fail++; $display("FAIL preempt_id j=%0d got %0d want %0d", j, bus.o_sfx_id, ei); end
      n_tests++;
      if (bus.o_done !== ed) begin n_fail++; $display("FAIL preempt_done j=%0d got %0b want %0b", j, bus.o_done, ed); end
      bus.i_sfx_req = (j == 26) ? 3'b100 : 3'b000;
      tick();
    end
  endtask

  task automatic test_pending();
    logic [23:0] ef;
    logic [1:0]  ei;
    logic        ed;
    do_reset();
    start_fx(3'b010);
    for (int j = 0; j <= 193; j++) begin
      if (j < 128) begin
        ef = 24'(200 - 8 * (j / 8)); ei = 2'd1; ed = 1'b0;
      end else if (j < 192) begin
        ef = 24'(1600 - 100 * ((j - 128) / 8)); ei = 2'd0; ed = (j == 128);
      end else begin
        ef = 24'd261; ei = 2'd3; ed = (j == 192);
      end
      if (j != 192) begin
        n_tests++;
        if (bus.o_freq !== ef) begin n_fail++; $display("FAIL pending_freq j=%0d got %0d want %0d", j, bus.o_freq, ef); end
      end
      n_tests++;
      if (bus.o_sfx_id !== ei) begin n_fail++; $display("FAIL pending_id j=%0d got %0d want %0d", j, bus.o_sfx_id, ei); end
      n_tests++;
      if (bus.o_done !== ed) begin n_fail++; $display("FAIL pending_done j=%0d got %0b want %0b", j, bus.o_done, ed); end
      n_tests++;
      if (bus.o_sfx_active !== (j < 192)) begin n_fail++; $display("FAIL pending_active j=%0d got %0b", j, bus.o_sfx_active); end
      bus.i_sfx_req = (j == 10 || j == 20) ? 3'b001 : 3'b000;
      tick();
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] ei;
    int         n_done;
    n_done = 0;
    do_reset();
    start_fx(3'b111);
    for (int j = 0; j <= 290; j++) begin
      if (j < 96)       ei = 2'd2;
      else if (j < 224) ei = 2'd1;
      else if (j < 288) ei = 2'd0;
      else              ei = 2'd3;
      n_tests++;
      if (bus.o_sfx_id !== ei) begin n_fail++; $display("FAIL simul_id j=%0d got %0d want %0d", j, bus.o_sfx_id, ei); end
      n_tests++;
      if (bus.o_done !== (j == 96 || j == 224 || j == 288)) begin n_fail++; $display("FAIL simul_done j=%0d got %0b", j, bus.o_done); end
      if (bus.o_done === 1'b1) n_done++;
      tick();
    end
    n_tests++;
    if (n_done != 3) begin n_fail++; $display("FAIL simul_done_count got %0d want 3", n_done); end
  endtask

  task automatic test_mute();
    logic [23:0] ef;
    do_reset();
    start_fx(3'b100);
    for (int j = 0; j <= 40; j++) begin
      ef = (j >= 4 && j <= 19) ? 24'd0 : (((j / 8) % 2 == 0) ? 24'd440 : 24'd0);
      n_tests++;
      if (bus.o_freq !== ef) begin n_fail++; $display("FAIL mute_freq j=%0d got %0d want %0d", j, bus.o_freq, ef); end
      n_tests++;
      if (bus.o_sfx_id !== 2'd2 || bus.o_sfx_active !== 1'b1) begin n_fail++; $display("FAIL mute_id j=%0d got %0d/%0b want 2/1", j, bus.o_sfx_id, bus.o_sfx_active); end
      if (j == 3)  bus.i_mute = 1'b1;
      if (j == 19) bus.i_mute = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start_fx(3'b010);
    for (int j = 0; j < 30; j++) begin
      bus.i_sfx_req = (j == 5) ? 3'b001 : 3'b000;
      tick();
    end
    rst = 1'b1;
    tick();
    n_tests++;
    if (bus.o_freq !== 24'd0) begin n_fail++; $display("FAIL rstmid_freq got %0d want 0", bus.o_freq); end
    n_tests++;
    if (bus.o_sfx_active !== 1'b0 || bus.o_sfx_id !== 2'd3) begin n_fail++; $display("FAIL rstmid_id got %0b/%0d want 0/3", bus.o_sfx_active, bus.o_sfx_id); end
    n_tests++;
    if (bus.o_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %0b want 0", bus.o_done); end
    rst = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      n_tests++;
      if (bus.o_sfx_id !== 2'd3 || bus.o_freq !== 24'd261) begin n_fail++; $display("FAIL rstmid_pend_cleared j=%0d got id %0d freq %0d want 3/261", j, bus.o_sfx_id, bus.o_freq); end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    rst = 1'b1;
    bus.i_music_freq = 24'd0;
    bus.i_sfx_req = 3'b000;
    bus.i_mute = 1'b0;
    test_reset();
    test_idle();
    test_laser();
    test_preempt();
    test_pending();
    test_simultaneous();
    test_mute();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_arbiter.md
AUDIO_ARBITER -- requirements
Module: audio_arbiter

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 50_000_000, meaning the input clock frequency in Hz.
REQ-002 The block SHALL have parameter STEP_HZ, default 64, meaning the effect step rate in Hz; one step lasts STEP_CYC = CLK_HZ/STEP_HZ cycles (integer division).
REQ-003 Port i_clk  input  1  system clock; all logic on rising edge.
REQ-004 Port i_rst  input  1  reset, synchronous, active-high.
REQ-005 Port i_music_freq  input  24  current music note frequency in Hz; 0 = rest.
REQ-006 Port i_sfx_req  input  3  one-cycle request pulses: bit0 laser, bit1 explosion, bit2 player-hit.
REQ-007 Port i_mute  input  1  forces silent output.
REQ-008 Port o_freq  output  24  registered frequency for the shared tone generator.
REQ-009 Port o_sfx_active  output  1  high while an effect owns the tone generator.
REQ-010 Port o_sfx_id  output  2  running effect id 0/1/2; 3 = none.
REQ-011 Port o_done  output  1  one-cycle pulse when an effect completes or is preempted.

Function
REQ-012 The FSM SHALL have states IDLE (music owns o_freq) and PLAY (effect owns o_freq).
REQ-013 Effect tables SHALL be: laser 8 steps, freq = 1600 - 100*s (1600..900); explosion 16 steps, freq = 200 - 8*s (200..80); hit 12 steps, freq = 440 on even s, 0 on odd s.
REQ-014 Priority SHALL be hit > explosion > laser.
REQ-015 In IDLE, o_freq SHALL equal i_music_freq sampled on the previous edge (1-cycle latency).
REQ-016 A request sampled at edge N SHALL start its effect: at N+1 state = PLAY, step = 0, o_freq = step-0 value, o_sfx_active = 1, o_sfx_id = id.
REQ-017 The step counter SHALL clear on every effect start; each step lasts exactly STEP_CYC cycles, then step increments.
REQ-018 After the last step's STEP_CYC cycles expire, o_done SHALL pulse for one cycle and the FSM SHALL start the highest pending effect if any; otherwise it SHALL return to IDLE with o_sfx_id = 3 in the same cycle.
REQ-019 Simultaneous requests SHALL start the highest; the others SHALL be set in a 3-bit pending register.
REQ-020 A request of higher priority than the running effect SHALL abort it: o_done pulses, the new effect starts at the next edge, and the aborted effect is discarded (not resumed, not made pending).
REQ-021 A request of lower priority than the running effect SHALL set its pending bit; repeated requests SHALL not count (one pending bit per id).
REQ-022 A request with the same id as the running effect SHALL restart it from step 0 without pulsing o_done.
REQ-023 A pending bit SHALL clear when its effect starts.
REQ-024 i_mute = 1 SHALL force o_freq = 0 at the next edge; FSM, counters and pending bits SHALL continue unaffected.
REQ-025 Music frequency changes during PLAY SHALL be ignored; o_freq tracks music again starting 1 cycle after return to IDLE.

Reset
REQ-026 i_rst = 1 at a rising edge SHALL set: state IDLE, o_freq = 0, o_sfx_active = 0, o_sfx_id = 3, o_done = 0, pending = 0, step and cycle counters = 0; requests during reset are dropped.
REQ-027 Reset SHALL override every other event in the same cycle, including mid-effect.

Verification (CLK_HZ = 64, STEP_HZ = 8, so STEP_CYC = 8)
REQ-028 Idle passthrough: i_music_freq = 261 -> o_freq = 261 one cycle later, o_sfx_id = 3.
REQ-029 Laser alone: pulse bit0 at edge N -> o_freq 1600 from N+1 to N+8, then 1500 from N+9; o_done at N+65; o_freq = music from N+66.
REQ-030 Preempt: start laser, pulse hit at step 3 -> o_done pulse, then o_freq = 440, o_sfx_id = 2; laser does not resume after hit ends.
REQ-031 Pending: during explosion, pulse laser twice -> laser runs exactly once after explosion's o_done, with no IDLE cycle in between.
REQ-032 Simultaneous bits 0b111 -> hit runs, then explosion, then laser; three o_done pulses.
REQ-033 Mute and reset: i_mute mid-hit -> o_freq = 0, and the step timing is unchanged on unmute; i_rst mid-explosion -> all outputs at reset values next cycle, pending cleared.
